// File: rtl/wb_pkg.sv
// Shared types for the writeback port arbiter.
//   WB_DATA_W / WB_REG_W : default register data / address widths
//   wb_state_t           : starvation FSM states
//   wb_result_t          : one pending long-latency result {dest, data}
package wb_pkg;

   localparam int WB_DATA_W = 32;
   localparam int WB_REG_W  = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      FORCE = 2'd2
   } wb_state_t;

   typedef struct packed {
      logic [WB_REG_W-1:0]  dest;
      logic [WB_DATA_W-1:0] data;
   } wb_result_t;

   localparam int WB_RES_W = $bits(wb_result_t);

endpackage

// File: rtl/wb_pend_fifo.sv
// Pending-result FIFO for long-latency unit results.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_push, i_wr_data     write one packed wb_result_t at the tail (ignored when full)
//   i_pop                 drop the head entry (ignored when empty)
//   o_rd_data             current head entry
//   o_count               number of stored entries
//   o_full, o_empty       status flags
// DEPTH must be a power of two (>= 2) so the pointers wrap by overflow.
module wb_pend_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_push,
   input  logic [WB_RES_W-1:0]      i_wr_data,
   input  logic                     i_pop,
   output logic [WB_RES_W-1:0]      o_rd_data,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic                     o_empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   wb_result_t       r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_rd_data = r_mem[r_rd_ptr];

   assign w_push = i_push && !o_full;
   assign w_pop  = i_pop && !o_empty;

   // storage needs no reset: count gates every read
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CNT_W'(1);
         end else if (w_pop && !w_push) begin
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter between the in-order writeback stage and
// the long-latency (mul/div) unit.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | pending buffer empty, starve counter at 0
// WAIT  | buffer holds results, counting cycles the head loses to pipe
// FORCE | head starved STARVE_MAX cycles, stall_req held high
//
// Ports:
//   i_clk, i_rst                        clock, synchronous active-high reset
//   i_pipe_we/_dest/_data               stage-5 writeback (always highest priority)
//   i_lu_valid/_dest/_data, o_lu_ready  long-latency result handshake
//   o_rf_we/_waddr/_wdata               registered register-file write port
//   o_stall_req                         registered request for a writeback bubble
//   o_pend_cnt                          results waiting in the buffer
// DATA_W/REG_W must match the wb_pkg defaults, since the buffered struct uses them.
module wb_port_arbiter #(
   parameter int DATA_W     = wb_pkg::WB_DATA_W,
   parameter int REG_W      = wb_pkg::WB_REG_W,
   parameter int DEPTH      = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_pipe_we,
   input  logic [REG_W-1:0]       i_pipe_dest,
   input  logic [DATA_W-1:0]      i_pipe_data,
   input  logic                   i_lu_valid,
   output logic                   o_lu_ready,
   input  logic [REG_W-1:0]       i_lu_dest,
   input  logic [DATA_W-1:0]      i_lu_data,
   output logic                   o_rf_we,
   output logic [REG_W-1:0]       o_rf_waddr,
   output logic [DATA_W-1:0]      o_rf_wdata,
   output logic                   o_stall_req,
   output logic [$clog2(DEPTH):0] o_pend_cnt
);

   import wb_pkg::*;

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int SC_W  = 4;

   wb_state_t         r_state;
   logic [SC_W-1:0]   r_starve;
   logic              r_stall;
   logic              r_rf_we;
   logic [REG_W-1:0]  r_rf_waddr;
   logic [DATA_W-1:0] r_rf_wdata;

   wb_result_t        w_lu_res;
   wb_result_t        w_head;
   logic [CNT_W-1:0]  w_fifo_cnt;
   logic              w_fifo_full;
   logic              w_fifo_empty;
   logic              w_lu_xfer;
   logic              w_bypass;
   logic              w_push;
   logic              w_pop;
   logic              w_denied;
   logic              w_empty_after;
   logic              w_gnt;
   logic [REG_W-1:0]  w_gnt_dest;
   logic [DATA_W-1:0] w_gnt_data;

   assign w_lu_res.dest = i_lu_dest;
   assign w_lu_res.data = i_lu_data;

   // ready looks only at registered occupancy, so a same-cycle pop cannot
   // open the buffer for the held result until the next cycle
   assign o_lu_ready = !i_rst && !w_fifo_full;
   assign w_lu_xfer  = i_lu_valid && o_lu_ready;

   assign w_pop    = !i_pipe_we && !w_fifo_empty;
   assign w_bypass = !i_pipe_we && w_fifo_empty && i_lu_valid;
   assign w_push   = w_lu_xfer && !w_bypass;
   assign w_denied = i_pipe_we && !w_fifo_empty;

   // the last entry leaves and nothing replaces it
   assign w_empty_after = (w_fifo_cnt == CNT_W'(1)) && w_pop && !w_push;

   wb_pend_fifo #(
      .DEPTH (DEPTH)
   ) u_pend_fifo (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_push    (w_push),
      .i_wr_data (w_lu_res),
      .i_pop     (w_pop),
      .o_rd_data (w_head),
      .o_count   (w_fifo_cnt),
      .o_full    (w_fifo_full),
      .o_empty   (w_fifo_empty)
   );

   always_comb begin
      w_gnt      = 1'b0;
      w_gnt_dest = '0;
      w_gnt_data = '0;
      if (i_pipe_we) begin
         w_gnt      = 1'b1;
         w_gnt_dest = i_pipe_dest;
         w_gnt_data = i_pipe_data;
      end else if (!w_fifo_empty) begin
         w_gnt      = 1'b1;
         w_gnt_dest = w_head.dest;
         w_gnt_data = w_head.data;
      end else if (i_lu_valid) begin
         w_gnt      = 1'b1;
         w_gnt_dest = i_lu_dest;
         w_gnt_data = i_lu_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= IDLE;
         r_starve <= '0;
         r_stall  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_push) begin
                  r_state <= WAIT;
               end
            end
            WAIT: begin
               if (w_pop) begin
                  r_starve <= '0;
                  if (w_empty_after) begin
                     r_state <= IDLE;
                  end
               end else if (w_denied) begin
                  r_starve <= r_starve + SC_W'(1);
                  if (r_starve + SC_W'(1) == SC_W'(STARVE_MAX)) begin
                     r_state <= FORCE;
                     r_stall <= 1'b1;
                  end
               end
            end
            FORCE: begin
               // a pipe write here violates the bubble protocol; the pipe still
               // wins and the counter holds until the head finally drains
               if (w_pop) begin
                  r_starve <= '0;
                  r_stall  <= 1'b0;
                  r_state  <= w_empty_after ? IDLE : WAIT;
               end
            end
            default: begin
               r_state  <= IDLE;
               r_starve <= '0;
               r_stall  <= 1'b0;
            end
         endcase
      end
   end

   // register 0 writes still take the slot but never reach the file
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rf_we    <= 1'b0;
         r_rf_waddr <= '0;
         r_rf_wdata <= '0;
      end else begin
         r_rf_we <= w_gnt && (w_gnt_dest != '0);
         if (w_gnt) begin
            r_rf_waddr <= w_gnt_dest;
            r_rf_wdata <= w_gnt_data;
         end
      end
   end

   assign o_rf_we     = r_rf_we;
   assign o_rf_waddr  = r_rf_waddr;
   assign o_rf_wdata  = r_rf_wdata;
   assign o_stall_req = r_stall;
   assign o_pend_cnt  = w_fifo_cnt;

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

   localparam int DATA_W     = 32;
   localparam int REG_W      = 5;
   localparam int DEPTH      = 2;
   localparam int STARVE_MAX = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              pipe_we;
   logic [REG_W-1:0]  pipe_dest;
   logic [DATA_W-1:0] pipe_data;
   logic              lu_valid;
   logic              lu_ready;
   logic [REG_W-1:0]  lu_dest;
   logic [DATA_W-1:0] lu_data;
   logic              rf_we;
   logic [REG_W-1:0]  rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic              stall_req;
   logic [1:0]        pend_cnt;

   always #5 clk = ~clk;

   wb_port_arbiter #(
      .DATA_W     (DATA_W),
      .REG_W      (REG_W),
      .DEPTH      (DEPTH),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_pipe_we   (pipe_we),
      .i_pipe_dest (pipe_dest),
      .i_pipe_data (pipe_data),
      .i_lu_valid  (lu_valid),
      .o_lu_ready  (lu_ready),
      .i_lu_dest   (lu_dest),
      .i_lu_data   (lu_data),
      .o_rf_we     (rf_we),
      .o_rf_waddr  (rf_waddr),
      .o_rf_wdata  (rf_wdata),
      .o_stall_req (stall_req),
      .o_pend_cnt  (pend_cnt)
   );

   typedef struct {
      int                cyc;
      logic [REG_W-1:0]  a;
      logic [DATA_W-1:0] d;
   } exp_t;

   typedef struct {
      logic [REG_W-1:0]  a;
      logic [DATA_W-1:0] d;
   } res_t;

   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   bit   mon_en = 0;
   exp_t exp_q[$];
   exp_t mon_e;

   // reference model: pending results in arrival order plus starvation count
   res_t m_q[$];
   int   m_starve = 0;
   bit   m_stall  = 0;

   logic s_stall;
   logic s_rfwe;
   logic s_ready;
   logic [1:0] s_pend;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // monitor: every presented write must match the oldest expectation and its cycle
   always @(negedge clk) begin
      if (mon_en) begin
         if (rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_write", {59'd0, rf_waddr}, 64'd0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("wr_cycle", cyc, mon_e.cyc);
               chk("wr_addr", rf_waddr, mon_e.a);
               chk("wr_data", rf_wdata, mon_e.d);
            end
         end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            mon_e = exp_q.pop_front();
            chk("missing_write", {59'd0, rf_we === 1'b1 ? 5'd0 : 5'd0} | 64'd0, 64'd1);
         end
      end
   end

   task automatic step(input logic pw, input logic [REG_W-1:0] pd, input logic [DATA_W-1:0] pdat,
                       input logic lv, input logic [REG_W-1:0] ld, input logic [DATA_W-1:0] ldat,
                       output bit accepted);
      bit                got;
      bit                popped;
      bit                bypassed;
      bit                denied;
      logic [REG_W-1:0]  ga;
      logic [DATA_W-1:0] gd;
      res_t              r;
      pipe_we   = pw;
      pipe_dest = pd;
      pipe_data = pdat;
      lu_valid  = lv;
      lu_dest   = ld;
      lu_data   = ldat;
      @(negedge clk);
      s_stall = stall_req;
      s_rfwe  = rf_we;
      s_ready = lu_ready;
      s_pend  = pend_cnt;
      chk("lu_ready", lu_ready, m_q.size() < DEPTH);
      chk("pend_cnt", pend_cnt, m_q.size());
      chk("stall_req", stall_req, m_stall);
      accepted = lv && (m_q.size() < DEPTH);
      got = 0; popped = 0; bypassed = 0; denied = 0; ga = '0; gd = '0;
      if (pw) begin
         got = 1; ga = pd; gd = pdat; denied = (m_q.size() > 0);
      end else if (m_q.size() > 0) begin
         r = m_q.pop_front();
         got = 1; ga = r.a; gd = r.d; popped = 1;
      end else if (lv) begin
         got = 1; ga = ld; gd = ldat; bypassed = 1;
      end
      if (accepted && !bypassed) m_q.push_back('{a: ld, d: ldat});
      if (denied && m_starve < STARVE_MAX) m_starve++;
      if (popped || m_q.size() == 0) m_starve = 0;
      m_stall = (m_q.size() > 0) && (m_starve >= STARVE_MAX);
      if (got && ga != '0) exp_q.push_back('{cyc: cyc + 1, a: ga, d: gd});
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      pipe_we = 0; pipe_dest = '0; pipe_data = '0;
      lu_valid = 0; lu_dest = '0; lu_data = '0;
      @(negedge clk);
      chk("rst_lu_ready", lu_ready, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_q.delete();
      m_starve = 0;
      m_stall  = 0;
      @(negedge clk);
      chk("rst_pend_cnt", pend_cnt, 2'd0);
      chk("rst_stall", stall_req, 1'b0);
      chk("rst_rf_we", rf_we, 1'b0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit                acc;
      bit                lv_pend;
      logic [REG_W-1:0]  ld;
      logic [DATA_W-1:0] ldat;
      logic [REG_W-1:0]  pd;
      logic [DATA_W-1:0] pdat;
      logic              pw;
      int                pw_pct;

      rst = 1'b1;
      pipe_we = 0; pipe_dest = '0; pipe_data = '0;
      lu_valid = 0; lu_dest = '0; lu_data = '0;
      @(negedge clk);
      chk("init_rf_we", rf_we, 1'b0);
      chk("init_rf_waddr", rf_waddr, 5'd0);
      chk("init_rf_wdata", rf_wdata, 32'd0);
      chk("init_stall", stall_req, 1'b0);
      chk("init_pend", pend_cnt, 2'd0);
      chk("init_lu_ready", lu_ready, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      mon_en = 1;

      // pipeline only, then bypass
      step(1, 5'd5, 32'hDEADBEEF, 0, '0, '0, acc);
      chk("pipe_ready", s_ready, 1'b1);
      step(0, '0, '0, 1, 5'd9, 32'h1234, acc);
      step(0, '0, '0, 0, '0, '0, acc);
      chk("bypass_pend", s_pend, 2'd0);

      // collision then drain
      step(1, 5'd3, 32'hA3A3, 1, 5'd7, 32'hB7B7, acc);
      step(0, '0, '0, 0, '0, '0, acc);
      chk("collide_pend", s_pend, 2'd1);
      step(0, '0, '0, 0, '0, '0, acc);
      chk("drain_pend", s_pend, 2'd0);

      // starvation: one buffered result, pipe holds the port for 6 cycles
      step(1, 5'd4, 32'h4, 1, 5'd8, 32'h88, acc);
      for (int k = 1; k <= 6; k++) begin
         step(1, 5'(k + 10), 32'(k), 0, '0, '0, acc);
         chk($sformatf("starve_hold%0d", k), s_stall, (k >= 5) ? 1'b1 : 1'b0);
      end
      step(0, '0, '0, 0, '0, '0, acc);
      chk("starve_drop_still", s_stall, 1'b1);
      step(0, '0, '0, 0, '0, '0, acc);
      chk("starve_released", s_stall, 1'b0);

      // full buffer: third result waits until a slot frees
      step(1, 5'd1, 32'h11, 1, 5'd20, 32'h2020, acc);
      step(1, 5'd2, 32'h22, 1, 5'd21, 32'h2121, acc);
      step(1, 5'd6, 32'h66, 1, 5'd22, 32'h2222, acc);
      chk("full_ready", s_ready, 1'b0);
      chk("full_pend", s_pend, 2'd2);
      chk("full_acc", acc, 1'b0);
      step(0, '0, '0, 1, 5'd22, 32'h2222, acc);
      chk("full_pop_no_ready", s_ready, 1'b0);
      step(0, '0, '0, 1, 5'd22, 32'h2222, acc);
      chk("full_late_acc", acc, 1'b1);
      step(0, '0, '0, 0, '0, '0, acc);
      step(0, '0, '0, 0, '0, '0, acc);

      // reset with a full buffer, then a write to r0
      step(1, 5'd1, 32'h1, 1, 5'd13, 32'h13, acc);
      step(1, 5'd2, 32'h2, 1, 5'd14, 32'h14, acc);
      step(1, 5'd3, 32'h3, 0, '0, '0, acc);
      chk("pre_rst_pend", s_pend, 2'd2);
      do_reset();
      step(1, 5'd0, 32'hFFFF, 0, '0, '0, acc);
      step(0, '0, '0, 0, '0, '0, acc);
      chk("r0_no_we", s_rfwe, 1'b0);

      // randomized traffic
      lv_pend = 0; ld = '0; ldat = '0; pw_pct = 50;
      for (int i = 0; i < 600; i++) begin
         if (i == 250 || i == 450) begin
            do_reset();
            lv_pend = 0;
         end
         if (i % 60 == 0) pw_pct = $urandom_range(20, 95);
         pw   = ($urandom_range(0, 99) < pw_pct);
         pd   = 5'($urandom_range(0, 31));
         pdat = $urandom;
         if (!lv_pend && $urandom_range(0, 2) == 0) begin
            lv_pend = 1;
            ld      = 5'($urandom_range(0, 31));
            ldat    = $urandom;
         end
         step(pw, pd, pdat, lv_pend, ld, ldat, acc);
         if (acc) lv_pend = 0;
      end

      for (int i = 0; i < 8; i++) step(0, '0, '0, 0, '0, '0, acc);
      chk("drain_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
